// File: rtl/dual_fetch_queue.sv
// Purpose : fetch front end; issues two-word fetches, buffers {inst,pc} pairs in a circular queue,
//           presents up to two in-order instructions per cycle to a dual-issue decoder.
// Latency : request -> entries visible at the outputs two clock edges later (one memory, one push).
// Backpressure: decode pops 0..2 per cycle; fetch is throttled so the queue can absorb every
//           response already in flight, so the queue never overflows.
// Ports   : clk/reset (sync, active-high); imem_req/imem_addr out, imem_rdata0/1 in (1-cycle latency);
//           redirect_valid/redirect_pc flush+restart; issue_pop = entries taken by decode;
//           inst0/pc0/inst0_valid = head entry, inst1/pc1/inst1_valid = head+1 entry.
module dual_fetch_queue #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata0,
  input  logic [31:0] imem_rdata1,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic [1:0]  issue_pop,
  output logic        inst0_valid,
  output logic [31:0] inst0,
  output logic [31:0] pc0,
  output logic        inst1_valid,
  output logic [31:0] inst1,
  output logic [31:0] pc1
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic          inflight_q, inflight_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   inst_mem_d [DEPTH];
  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   pc_mem_d   [DEPTH];

  logic          push;
  logic [1:0]    pop_req;
  logic [1:0]    pop_eff;
  logic [CW+1:0] need;
  logic [CW:0]   count_wide;
  logic [AW-1:0] head_p1;
  logic [AW-1:0] tail_p1;

  // Low address bits of a redirect are dropped; fold them here so the drop is explicit.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Reserve room for this request plus any response still in flight.
  always_comb begin
    need      = (CW+2)'(count_q) + (inflight_q ? (CW+2)'(4) : (CW+2)'(2));
    imem_req  = !reset && !redirect_valid && (need <= (CW+2)'(DEPTH));
    imem_addr = fetch_pc_q;
  end

  // Effective pop = min(issue_pop, count, 2); illegal requests are clamped here.
  always_comb begin
    pop_req = (issue_pop == 2'd3) ? 2'd2 : issue_pop;
    pop_eff = pop_req;
    if (count_q < CW'(pop_req)) begin
      pop_eff = count_q[1:0];
    end
  end

  assign push    = inflight_q && !redirect_valid;
  assign tail_p1 = tail_q + AW'(1);
  assign head_p1 = head_q + AW'(1);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    inflight_d = 1'b0;
    head_d     = head_q;
    tail_d     = tail_q;
    count_wide = (CW+1)'(count_q) - (CW+1)'(pop_eff) + (push ? (CW+1)'(2) : '0);
    count_d    = count_wide[CW-1:0];
    inst_mem_d = inst_mem_q;
    pc_mem_d   = pc_mem_q;

    if (redirect_valid) begin
      // Flush: the queue empties and any response landing this cycle is dropped.
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      head_d = head_q + AW'(pop_eff);
      if (push) begin
        inst_mem_d[tail_q]  = imem_rdata0;
        pc_mem_d[tail_q]    = req_addr_q;
        inst_mem_d[tail_p1] = imem_rdata1;
        pc_mem_d[tail_p1]   = req_addr_q + 32'd4;
        tail_d              = tail_q + AW'(2);
      end
      if (imem_req) begin
        fetch_pc_d = fetch_pc_q + 32'd8;
        req_addr_d = fetch_pc_q;
        inflight_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      req_addr_q <= '0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        inst_mem_q[k] <= '0;
        pc_mem_q[k]   <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      inst_mem_q <= inst_mem_d;
      pc_mem_q   <= pc_mem_d;
    end
  end

  // Outputs depend only on queue registers; empty slots read as zero.
  always_comb begin
    inst0_valid = (count_q >= CW'(1));
    inst1_valid = (count_q >= CW'(2));
    inst0       = inst0_valid ? inst_mem_q[head_q]  : '0;
    pc0         = inst0_valid ? pc_mem_q[head_q]    : '0;
    inst1       = inst1_valid ? inst_mem_q[head_p1] : '0;
    pc1         = inst1_valid ? pc_mem_q[head_p1]   : '0;
  end

  a_pop_legal : assert property (@(posedge clk) disable iff (reset)
    !redirect_valid |-> (issue_pop != 2'd3 && CW'(issue_pop) <= count_q));

  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    redirect_valid || (count_wide <= (CW+1)'(DEPTH)));

endmodule

// File: tb/tb_dual_fetch_queue.sv
module tb_dual_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata0;
  logic [31:0] imem_rdata1;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  issue_pop;
  logic        inst0_valid;
  logic [31:0] inst0;
  logic [31:0] pc0;
  logic        inst1_valid;
  logic [31:0] inst1;
  logic [31:0] pc1;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  dual_fetch_queue #(.DEPTH(8), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata0    (imem_rdata0),
    .imem_rdata1    (imem_rdata1),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .issue_pop      (issue_pop),
    .inst0_valid    (inst0_valid),
    .inst0          (inst0),
    .pc0            (pc0),
    .inst1_valid    (inst1_valid),
    .inst1          (inst1),
    .pc1            (pc1)
  );

  always #5 clk = ~clk;

  // Instruction memory: every word holds its own address, one cycle after the address.
  always @(posedge clk) begin
    imem_rdata0 <= imem_addr;
    imem_rdata1 <= imem_addr + 32'd4;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected fetch stream after a (re)start: linear words from base.
  task automatic load_exp(input logic [31:0] base, input int n);
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back(base + 32'(4 * k));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every entry decode takes must match the next expected PC (inst == pc here).
  always @(negedge clk) begin
    logic [31:0] e;
    if (!reset && !redirect_valid) begin
      for (int k = 0; k < 2; k++) begin
        if (k < int'(issue_pop)) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: got pop of %h with no expected entry", (k == 0) ? pc0 : pc1);
          end else begin
            e = exp_q.pop_front();
            chk("sb_valid", 32'((k == 0) ? inst0_valid : inst1_valid), 32'd1);
            chk("sb_pc",   (k == 0) ? pc0   : pc1,   e);
            chk("sb_inst", (k == 0) ? inst0 : inst1, e);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nreq;
    int want;
    int avail;
    bit found;

    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    issue_pop      = 2'd0;

    // Reset held two cycles: everything quiet.
    repeat (2) begin
      @(negedge clk);
      chk("rst_v0",    32'(inst0_valid), 32'd0);
      chk("rst_v1",    32'(inst1_valid), 32'd0);
      chk("rst_req",   32'(imem_req),    32'd0);
      chk("rst_pc0",   pc0,              32'd0);
      chk("rst_inst1", inst1,            32'd0);
    end
    step();
    reset = 1'b0;
    load_exp(32'h0, 256);

    // First fetch then fill with no pops: exactly four requests 0,8,0x10,0x18.
    nreq = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) chk("first_req", 32'(imem_req), 32'd1);
      if (imem_req) begin
        chk("fill_addr", imem_addr, 32'(nreq * 8));
        nreq++;
      end
      if (c == 2) begin
        chk("first_v0",    32'(inst0_valid), 32'd1);
        chk("first_pc0",   pc0,   32'h0);
        chk("first_inst0", inst0, 32'h0);
        chk("first_pc1",   pc1,   32'h4);
        chk("first_inst1", inst1, 32'h4);
      end
      step();
    end
    chk("fill_nreq", 32'(nreq), 32'd4);
    chk("full_v1",   32'(inst1_valid), 32'd1);
    chk("full_pc0",  pc0, 32'h0);
    chk("full_pc1",  pc1, 32'h4);

    // Sustained dual pop from full: no bubble, a request every cycle once space opens.
    issue_pop = 2'd2;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("tput_v1", 32'(inst1_valid), 32'd1);
      if (c >= 1) chk("tput_req", 32'(imem_req), 32'd1);
      step();
    end

    // Alternating 1/2 pops across many pointer wraps.
    for (int c = 0; c < 30; c++) begin
      want  = (c % 2 == 0) ? 1 : 2;
      avail = int'(inst0_valid) + int'(inst1_valid);
      issue_pop = 2'((want < avail) ? want : avail);
      step();
    end

    // Redirect in the cycle a response returns.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      issue_pop = inst1_valid ? 2'd2 : (inst0_valid ? 2'd1 : 2'd0);
      @(negedge clk);
      found = imem_req;
      step();
    end
    chk("redir_found", 32'(found), 32'd1);
    issue_pop      = 2'd0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    load_exp(32'h100, 64);
    @(negedge clk);
    chk("redir_req", 32'(imem_req), 32'd0);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_v0",   32'(inst0_valid), 32'd0);
    chk("redir_v1",   32'(inst1_valid), 32'd0);
    chk("redir_req1", 32'(imem_req), 32'd1);
    chk("redir_addr", imem_addr, 32'h100);
    step();
    step();
    @(negedge clk);
    chk("redir_pc0",   pc0,   32'h100);
    chk("redir_inst0", inst0, 32'h100);
    chk("redir_pc1",   pc1,   32'h104);
    step();
    step();

    // Queue now holds six entries with the 0x118 fetch in flight: reset.
    reset = 1'b1;
    @(negedge clk);
    chk("rst2_req", 32'(imem_req), 32'd0);
    step();
    @(negedge clk);
    chk("rst2_v0", 32'(inst0_valid), 32'd0);
    chk("rst2_v1", 32'(inst1_valid), 32'd0);
    step();
    reset = 1'b0;
    load_exp(32'h0, 64);
    @(negedge clk);
    chk("rst2_v0b",  32'(inst0_valid), 32'd0);
    chk("rst2_req1", 32'(imem_req), 32'd1);
    chk("rst2_addr", imem_addr, 32'h0);
    for (int c = 0; c < 12; c++) begin
      step();
      issue_pop = inst1_valid ? 2'd2 : (inst0_valid ? 2'd1 : 2'd0);
    end
    step();
    issue_pop = 2'd0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
